ps2_rx_decoder: RTL and testbench

- PS/2 keyboard receive front-end that feeds Keyboard_Ctrl and Keyboard via ps2_byte and ps2_state.
- Synchronises the raw ps2k_clk/ps2k_data pins and deserialises 11-bit device-to-host frames with start, parity and stop checks.
- Decodes the scan-code prefixes E0 (extended) and F0 (break) into held-key state plus one-cycle make/break strobes.
- Replaces the receive portion of ps2_top; carries no seven-segment or LED debug logic.

---
 rtl/ps2_rx_decoder_if.sv | 28 ++
 rtl/ps2_rx_decoder.sv | 172 +++++++++++++++++
 tb/tb_ps2_rx_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_decoder_if.sv
// Decoded PS/2 key event bundle: held-key state plus make/break/error strobes.
// The decoder drives it through the master modport; consumers use the slave modport.
interface ps2_rx_decoder_if;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic       ps2_ext;
    logic       make_pulse;
    logic       break_pulse;
    logic       frame_err;

    modport master (
        output ps2_byte,
        output ps2_state,
        output ps2_ext,
        output make_pulse,
        output break_pulse,
        output frame_err
    );

    modport slave (
        input ps2_byte,
        input ps2_state,
        input ps2_ext,
        input make_pulse,
        input break_pulse,
        input frame_err
    );
endinterface

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: pin synchronisation, 11-bit frame deserialisation with checks,
// and E0/F0 prefix decoding into a held key plus one-cycle make/break/error strobes.
module ps2_rx_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             CLK_50M,
    input  logic             RSTn,
    input  logic             ps2k_clk,
    input  logic             ps2k_data,
    ps2_rx_decoder_if.master rx
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] IdleLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_hist_q;
    logic                   clk_s, data_s, fall;

    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [CntW-1:0] idle_q, idle_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    dec_state_e state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_q, ext_d;
    logic       held_q, held_d;
    logic       make_q, make_d;
    logic       brk_q, brk_d;
    logic       ferr_q;
    logic       make_ext;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_hist_q & ~clk_s;

    // Synchronisers reset to the bus idle level so reset release cannot fake an edge.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_hist_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2k_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2k_data};
            clk_hist_q  <= clk_s;
        end
    end

    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        idle_d  = idle_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (bit_q == 4'd0) begin
                if (data_s) err_d = 1'b1;
                else        bit_d = 4'd1;
            end else if (bit_q <= 4'd8) begin
                shift_d = {data_s, shift_q[7:1]};
                bit_d   = bit_q + 4'd1;
            end else if (bit_q == 4'd9) begin
                par_d = data_s;
                bit_d = 4'd10;
            end else begin
                bit_d = 4'd0;
                if ((^{shift_q, par_q}) && data_s) valid_d = 1'b1;
                else                               err_d   = 1'b1;
            end
        end else if (bit_q != 4'd0) begin
            if (idle_q == IdleLast) begin
                bit_d  = 4'd0;
                idle_d = '0;
                err_d  = 1'b1;
            end else begin
                idle_d = idle_q + CntW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            bit_q   <= 4'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            idle_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idle_q  <= idle_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // shift_q still holds the accepted byte while valid_q is high.
    assign make_ext = (state_q == StExt);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        ext_d   = ext_q;
        held_d  = held_q;
        make_d  = 1'b0;
        brk_d   = 1'b0;
        if (valid_q) begin
            case (state_q)
                StIdle, StExt: begin
                    if (shift_q == 8'hF0) begin
                        state_d = make_ext ? StExtBrk : StBrk;
                    end else if (shift_q == 8'hE0) begin
                        state_d = StExt;
                    end else begin
                        byte_d  = shift_q;
                        ext_d   = make_ext;
                        held_d  = 1'b1;
                        make_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    brk_d = 1'b1;
                    if (shift_q == byte_q && (state_q == StExtBrk) == ext_q) held_d = 1'b0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            byte_q  <= 8'd0;
            ext_q   <= 1'b0;
            held_q  <= 1'b0;
            make_q  <= 1'b0;
            brk_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            ext_q   <= ext_d;
            held_q  <= held_d;
            make_q  <= make_d;
            brk_q   <= brk_d;
            ferr_q  <= err_q;
        end
    end

    assign rx.ps2_byte    = byte_q;
    assign rx.ps2_state   = held_q;
    assign rx.ps2_ext     = ext_q;
    assign rx.make_pulse  = make_q;
    assign rx.break_pulse = brk_q;
    assign rx.frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: scaled-down PS/2 bit rate and timeout keep the run short.
// Strobes are counted on the falling system clock edge; checks compare counter deltas.
module tb_ps2_rx_decoder;
    localparam int unsigned TOUT = 400;
    localparam int          HALF = 20;
    localparam int          QTR  = HALF / 2;

    logic CLK_50M = 1'b0;
    logic RSTn    = 1'b0;
    logic ps2k_clk  = 1'b1;
    logic ps2k_data = 1'b1;

    ps2_rx_decoder_if rx_if ();

    ps2_rx_decoder #(
        .TIMEOUT_CYCLES(TOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .CLK_50M  (CLK_50M),
        .RSTn     (RSTn),
        .ps2k_clk (ps2k_clk),
        .ps2k_data(ps2k_data),
        .rx       (rx_if.master)
    );

    always #10 CLK_50M = ~CLK_50M;

    int n_cmp = 0;
    int n_bad = 0;
    int make_cnt = 0, brk_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    logic make_prev = 1'b0, brk_prev = 1'b0, err_prev = 1'b0;

    always @(negedge CLK_50M) begin
        if (rx_if.make_pulse)  make_cnt++;
        if (rx_if.break_pulse) brk_cnt++;
        if (rx_if.frame_err)   err_cnt++;
        if ((32'(rx_if.make_pulse) + 32'(rx_if.break_pulse) + 32'(rx_if.frame_err)) > 1
            || (make_prev && rx_if.make_pulse) || (brk_prev && rx_if.break_pulse)
            || (err_prev && rx_if.frame_err))
            overlap_cnt++;
        make_prev = rx_if.make_pulse;
        brk_prev  = rx_if.break_pulse;
        err_prev  = rx_if.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
        logic p;
        p = (~^d) ^ bad_par;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Sends bits[0..n-1]; lat = negedges from the last falling ps2k_clk to the first strobe.
    task automatic send_bits(input logic [10:0] bits, input int n, output int lat);
        lat = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_50M);
            ps2k_data = bits[i];
            repeat (QTR) @(negedge CLK_50M);
            ps2k_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge CLK_50M);
                if (i == n - 1 && lat < 0
                    && (rx_if.make_pulse || rx_if.break_pulse || rx_if.frame_err))
                    lat = k;
            end
            ps2k_clk = 1'b1;
            repeat (QTR) @(negedge CLK_50M);
        end
        ps2k_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        int lat;
        send_bits(frame(d, 1'b0), 11, lat);
        repeat (5) @(negedge CLK_50M);
    endtask

    initial begin
        int lat, m0, b0, e0, tout_lat;

        repeat (3) @(negedge CLK_50M);
        chk("reset_byte", 32'(rx_if.ps2_byte), 32'h00);
        chk("reset_state", 32'(rx_if.ps2_state), 32'd0);
        chk("reset_ext", 32'(rx_if.ps2_ext), 32'd0);
        chk("reset_strobes", 32'({rx_if.make_pulse, rx_if.break_pulse, rx_if.frame_err}), 32'd0);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK_50M);

        // Plain make with latency check (2 sync stages + 2).
        m0 = make_cnt; e0 = err_cnt;
        send_bits(frame(8'h1C, 1'b0), 11, lat);
        repeat (5) @(negedge CLK_50M);
        chk("make_latency", 32'(lat), 32'd4);
        chk("make_count", 32'(make_cnt - m0), 32'd1);
        chk("make_no_err", 32'(err_cnt - e0), 32'd0);
        chk("make_byte", 32'(rx_if.ps2_byte), 32'h1C);
        chk("make_state", 32'(rx_if.ps2_state), 32'd1);
        chk("make_ext", 32'(rx_if.ps2_ext), 32'd0);

        // Break of the held key.
        m0 = make_cnt; b0 = brk_cnt;
        send(8'hF0);
        chk("f0_no_break_yet", 32'(brk_cnt - b0), 32'd0);
        chk("f0_state_held", 32'(rx_if.ps2_state), 32'd1);
        send(8'h1C);
        chk("break_count", 32'(brk_cnt - b0), 32'd1);
        chk("break_no_make", 32'(make_cnt - m0), 32'd0);
        chk("break_state", 32'(rx_if.ps2_state), 32'd0);
        chk("break_byte", 32'(rx_if.ps2_byte), 32'h1C);

        // Extended make and break.
        m0 = make_cnt; b0 = brk_cnt;
        send(8'hE0);
        send(8'h6B);
        chk("ext_make_byte", 32'(rx_if.ps2_byte), 32'h6B);
        chk("ext_make_ext", 32'(rx_if.ps2_ext), 32'd1);
        chk("ext_make_state", 32'(rx_if.ps2_state), 32'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        chk("ext_break_state", 32'(rx_if.ps2_state), 32'd0);
        chk("ext_break_ext", 32'(rx_if.ps2_ext), 32'd1);
        chk("ext_make_count", 32'(make_cnt - m0), 32'd1);
        chk("ext_break_count", 32'(brk_cnt - b0), 32'd1);

        // Break whose extended flag differs from the held key leaves it held.
        b0 = brk_cnt;
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        chk("mismatch_break_pulse", 32'(brk_cnt - b0), 32'd1);
        chk("mismatch_break_state", 32'(rx_if.ps2_state), 32'd1);
        chk("mismatch_break_ext", 32'(rx_if.ps2_ext), 32'd0);

        // Parity error drops the byte.
        m0 = make_cnt; e0 = err_cnt;
        send(8'h23);
        chk("pre_parity_byte", 32'(rx_if.ps2_byte), 32'h23);
        send_bits(frame(8'h1C, 1'b1), 11, lat);
        repeat (5) @(negedge CLK_50M);
        chk("parity_err_latency", 32'(lat), 32'd4);
        chk("parity_err_count", 32'(err_cnt - e0), 32'd1);
        chk("parity_no_make", 32'(make_cnt - m0), 32'd1);
        chk("parity_byte_kept", 32'(rx_if.ps2_byte), 32'h23);
        send(8'h3A);
        chk("after_parity_byte", 32'(rx_if.ps2_byte), 32'h3A);

        // Timeout: counter hits TOUT-1 TOUT+2 cycles after the pin edge, strobe two later.
        e0 = err_cnt; m0 = make_cnt;
        send_bits(frame(8'h1C, 1'b0), 5, lat);
        tout_lat = -1;
        for (int t = HALF + QTR + 1; t <= 3 * TOUT; t++) begin
            @(negedge CLK_50M);
            if (rx_if.frame_err && tout_lat < 0) tout_lat = t;
        end
        chk("timeout_latency", 32'(tout_lat), 32'(TOUT + 4));
        chk("timeout_err_count", 32'(err_cnt - e0), 32'd1);
        chk("timeout_no_make", 32'(make_cnt - m0), 32'd0);
        send(8'h1C);
        chk("after_timeout_byte", 32'(rx_if.ps2_byte), 32'h1C);
        chk("after_timeout_make", 32'(make_cnt - m0), 32'd1);
        chk("after_timeout_err", 32'(err_cnt - e0), 32'd1);

        // Reset mid-frame clears outputs asynchronously.
        send(8'h29);
        send_bits(frame(8'h1C, 1'b0), 7, lat);
        #3;
        RSTn = 1'b0;
        #1;
        chk("async_reset_byte", 32'(rx_if.ps2_byte), 32'h00);
        chk("async_reset_state", 32'(rx_if.ps2_state), 32'd0);
        repeat (4) @(negedge CLK_50M);
        RSTn = 1'b1;
        repeat (4) @(negedge CLK_50M);
        m0 = make_cnt; e0 = err_cnt;
        send(8'h1C);
        chk("post_reset_make", 32'(make_cnt - m0), 32'd1);
        chk("post_reset_no_err", 32'(err_cnt - e0), 32'd0);
        chk("post_reset_byte", 32'(rx_if.ps2_byte), 32'h1C);
        chk("post_reset_state", 32'(rx_if.ps2_state), 32'd1);

        chk("strobe_exclusive", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
